// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the multiply/divide unit: op bits, FSM states, HI/LO bus width.
package mdu_ctrl_pkg;

    localparam int MDU_OP_WD    = 4;
    localparam int MDU_OP_DIV   = 3;
    localparam int MDU_OP_DIVU  = 2;
    localparam int MDU_OP_MULT  = 1;
    localparam int MDU_OP_MULTU = 0;

    localparam int MDU_DATA_WD  = 32;
    localparam int MDU_TO_EX_WD = 2 * MDU_DATA_WD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Shift-add multiplier and restoring divider datapath; one step per enable.
// Exposes the post-step values so the controller can capture the final result on the last edge.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    output logic [2*WIDTH-1:0] prod_nxt,
    output logic [WIDTH-1:0]   quo_nxt,
    output logic [WIDTH-1:0]   rem_nxt
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH+1:0]   trial;

    always_comb begin
        prod_nxt = mplier[0] ? acc + mcand : acc;
        // Extra top bit holds the borrow; {rem,bit} < 2*divisor so W+1 magnitude bits suffice.
        trial = {1'b0, rem, quo[WIDTH-1]} - {2'b00, divisor};
        if (!trial[WIDTH+1]) begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
        end else if (load) begin
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, opa};
            mplier  <= opb;
            rem     <= '0;
            quo     <= opa;
            divisor <= opb;
        end else if (step) begin
            acc     <= prod_nxt;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            rem     <= rem_nxt;
            quo     <= quo_nxt;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns HI/LO and stalls EX while iterating.
// Operands are reduced to magnitudes on accept; the sign is restored when HI/LO are written.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    input  logic [MDU_OP_WD-1:0] op,
    input  logic [WIDTH-1:0]     src_a,
    input  logic [WIDTH-1:0]     src_b,
    input  logic                 mthi_we,
    input  logic                 mtlo_we,
    input  logic [WIDTH-1:0]     wdata,
    output logic                 stallreq,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdu_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic               quot_neg;
    logic               rem_neg;

    logic               legal;
    logic               is_div;
    logic               is_signed;
    logic               accept;
    logic               last;
    logic               iterating;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic [WIDTH-1:0]   rem_nxt;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;

    always_comb begin
        legal = 1'b0;
        case (op)
            4'b1000, 4'b0100, 4'b0010, 4'b0001: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
    end

    assign is_div    = op[MDU_OP_DIV] | op[MDU_OP_DIVU];
    assign is_signed = op[MDU_OP_DIV] | op[MDU_OP_MULT];
    assign a_mag     = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_mag     = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    // Illegal encodings never stall, otherwise EX would be frozen on them forever.
    assign accept    = (state == ST_IDLE) && op_valid && legal;
    assign stallreq  = accept | busy;
    assign iterating = (state == ST_MUL) || (state == ST_DIV);
    assign last      = cnt == CNT_W'(WIDTH - 1);

    assign mul_res = quot_neg ? -prod_nxt : prod_nxt;
    assign div_quo = quot_neg ? -quo_nxt  : quo_nxt;
    assign div_rem = rem_neg  ? -rem_nxt  : rem_nxt;

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     (iterating),
        .opa      (a_mag),
        .opb      (b_mag),
        .prod_nxt (prod_nxt),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            quot_neg <= 1'b0;
            rem_neg  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= is_div ? ST_DIV : ST_MUL;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        quot_neg <= is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        rem_neg  <= is_signed & src_a[WIDTH-1];
                    end else begin
                        if (mthi_we) hi <= wdata;
                        if (mtlo_we) lo <= wdata;
                    end
                end
                ST_MUL, ST_DIV: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        if (state == ST_MUL) begin
                            {hi, lo} <= mul_res;
                        end else begin
                            hi <= div_rem;
                            lo <= div_quo;
                        end
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency/stall window, signed/unsigned results, MT writes, reset abort.
module tb_mdu_ctrl;

    localparam logic [3:0] DIV   = 4'b1000;
    localparam logic [3:0] DIVU  = 4'b0100;
    localparam logic [3:0] MULT  = 4'b0010;
    localparam logic [3:0] MULTU = 4'b0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        mthi_we = 1'b0;
    logic        mtlo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        stallreq;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .mthi_we  (mthi_we),
        .mtlo_we  (mtlo_we),
        .wdata    (wdata),
        .stallreq (stallreq),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    // Presents one op like EX would, holding it until done, and reports the stall window.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output int lat, output bit tmo);
        @(negedge clk);
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        stalls = 0; lat = -1; tmo = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (done) begin
                lat = i; tmo = 1'b0;
                break;
            end
            if (stallreq) stalls++;
            @(negedge clk);
        end
        op_valid = 1'b0; op = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if ({stallreq, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b want=000", {stallreq, busy, done}); end
        total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL reset_hilo got=%h want=0", {hi, lo}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_multu_max;
        int s, l; bit t;
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s, l, t);
        total++; if (t !== 1'b0) begin bad++; $display("FAIL multu_timeout got=%0d want=0", t); end
        total++; if (s !== 33) begin bad++; $display("FAIL multu_stall got=%0d want=33", s); end
        total++; if (l !== 33) begin bad++; $display("FAIL multu_latency got=%0d want=33", l); end
        total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL multu_stall_in_done got=%b want=0", stallreq); end
        total++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL multu_result got=%h want=fffffffe00000001", {hi, lo}); end
    endtask

    task automatic test_mult_divu;
        int s, l; bit t;
        run_op(MULT, 32'hFFFF_FFFD, 32'd7, s, l, t);
        total++; if ({t, l} !== {1'b0, 32'd33}) begin bad++; $display("FAIL mult_latency got=%0d want=33", l); end
        total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL mult_neg got=%h want=ffffffffffffffeb", {hi, lo}); end
        run_op(MULT, 32'h8000_0000, 32'd2, s, l, t);
        total++; if ({hi, lo} !== 64'hFFFF_FFFF_0000_0000) begin bad++; $display("FAIL mult_minint got=%h want=ffffffff00000000", {hi, lo}); end
        run_op(DIVU, 32'd100, 32'd7, s, l, t);
        total++; if (s !== 33) begin bad++; $display("FAIL divu_stall got=%0d want=33", s); end
        total++; if ({hi, lo} !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu_result got=%h want=%h", {hi, lo}, {32'd2, 32'd14}); end
    endtask

    task automatic test_div_signed;
        int s, l; bit t;
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, s, l, t);
        total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_neg_dividend got=%h want=fffffffffffffffd", {hi, lo}); end
        run_op(DIV, 32'd7, 32'hFFFF_FFFE, s, l, t);
        total++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin bad++; $display("FAIL div_neg_divisor got=%h want=00000001fffffffd", {hi, lo}); end
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, s, l, t);
        total++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL div_overflow got=%h want=0000000080000000", {hi, lo}); end
    endtask

    task automatic test_div_zero;
        int s, l; bit t;
        run_op(DIV, 32'd5, 32'd0, s, l, t);
        total++; if ({hi, lo} !== 64'h0000_0005_FFFF_FFFF) begin bad++; $display("FAIL div_zero_signed got=%h want=00000005ffffffff", {hi, lo}); end
        run_op(DIVU, 32'd5, 32'd0, s, l, t);
        total++; if (t !== 1'b0) begin bad++; $display("FAIL divu_zero_timeout got=%0d want=0", t); end
        total++; if (s !== 33 || l !== 33) begin bad++; $display("FAIL divu_zero_timing got=%0d/%0d want=33/33", s, l); end
        total++; if ({hi, lo} !== 64'h0000_0005_FFFF_FFFF) begin bad++; $display("FAIL divu_zero_result got=%h want=00000005ffffffff", {hi, lo}); end
    endtask

    task automatic test_mt;
        bit seen;
        @(negedge clk);
        mthi_we = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        mthi_we = 1'b0;
        #1;
        total++; if (hi !== 32'h0000_1234) begin bad++; $display("FAIL mthi got=%h want=00001234", hi); end
        total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mthi_lo_kept got=%h want=ffffffff", lo); end
        @(negedge clk);
        mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h0000_CAFE;
        @(negedge clk);
        mthi_we = 1'b0; mtlo_we = 1'b0;
        #1;
        total++; if ({hi, lo} !== 64'h0000_CAFE_0000_CAFE) begin bad++; $display("FAIL mt_both got=%h want=0000cafe0000cafe", {hi, lo}); end
        // mtlo asserted alongside the op and held through DIV and DONE: all of it must be dropped.
        @(negedge clk);
        op_valid = 1'b1; op = DIVU; src_a = 32'd100; src_b = 32'd7;
        mtlo_we = 1'b1; wdata = 32'h0000_DEAD;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (i == 1 || i == 20) begin
                total++; if (lo !== 32'h0000_CAFE) begin bad++; $display("FAIL mtlo_during_div cyc=%0d got=%h want=0000cafe", i, lo); end
            end
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        op_valid = 1'b0; op = '0; mtlo_we = 1'b0;
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL mt_div_timeout got=%0d want=1", seen); end
        total++; if ({hi, lo} !== {32'd2, 32'd14}) begin bad++; $display("FAIL op_beats_mtlo got=%h want=%h", {hi, lo}, {32'd2, 32'd14}); end
        @(negedge clk);
        #1;
        total++; if (lo !== 32'd14) begin bad++; $display("FAIL mtlo_in_done got=%h want=0000000e", lo); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        op_valid = 1'b1; op = MULT; src_a = 32'hFFFF_FFFD; src_b = 32'd7;
        repeat (11) @(negedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
        rst = 1'b1; op_valid = 1'b0; op = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if ({stallreq, busy, done} !== 3'b000) begin bad++; $display("FAIL mid_reset_ctl got=%b want=000", {stallreq, busy, done}); end
        total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL mid_reset_hilo got=%h want=0", {hi, lo}); end
        repeat (40) @(negedge clk);
        #1;
        total++; if ({done, busy, hi, lo} !== 66'h0) begin bad++; $display("FAIL mid_reset_quiet got=%h want=0", {done, busy, hi, lo}); end
    endtask

    task automatic test_hold_through_done;
        int dones;
        dones = 0;
        @(negedge clk);
        op_valid = 1'b1; op = MULTU; src_a = 32'd6; src_b = 32'd7;
        for (int i = 0; i < 45; i++) begin
            #1;
            if (done) begin
                dones++;
                op_valid = 1'b0; op = '0;
            end
            @(negedge clk);
        end
        op_valid = 1'b0;
        #1;
        total++; if (dones !== 1) begin bad++; $display("FAIL done_pulses got=%0d want=1", dones); end
        total++; if ({hi, lo} !== 64'd42) begin bad++; $display("FAIL hold_result got=%h want=%h", {hi, lo}, 64'd42); end
    endtask

    task automatic test_illegal_op;
        logic [3:0] ill [3];
        ill[0] = 4'b0011; ill[1] = 4'b0000; ill[2] = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            op_valid = 1'b1; op = ill[k]; src_a = 32'd9; src_b = 32'd3;
            repeat (2) @(negedge clk);
            #1;
            total++; if ({stallreq, busy} !== 2'b00) begin bad++; $display("FAIL illegal_op op=%b got=%b want=00", ill[k], {stallreq, busy}); end
        end
        op_valid = 1'b0; op = '0;
        repeat (40) @(negedge clk);
        #1;
        total++; if ({done, hi, lo} !== {1'b0, 64'd42}) begin bad++; $display("FAIL illegal_hilo got=%h want=%h", {done, hi, lo}, {1'b0, 64'd42}); end
    endtask

    initial begin
        test_reset;
        test_multu_max;
        test_mult_divu;
        test_div_signed;
        test_div_zero;
        test_mt;
        test_reset_mid;
        test_hold_through_done;
        test_illegal_op;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
